// File: rtl/flasher_state_datapath_if.sv
// Generator <-> datapath bus of the bound flasher.
//   master : next-state generator (drives next state, counter controls)
//   slave  : flasher_state_datapath (drives registered state, counter,
//            synchronised flick and kickback request)
interface flasher_state_datapath_if;
   logic [2:0] main_state_n;
   logic [4:0] counter_load;
   logic       counter_load_en;
   logic [1:0] count_state;
   logic [2:0] main_state;
   logic [4:0] counter;
   logic       flick_sync;
   logic       kickback_match;

   modport master (
      output main_state_n, counter_load, counter_load_en, count_state,
      input  main_state, counter, flick_sync, kickback_match
   );

   modport slave (
      input  main_state_n, counter_load, counter_load_en, count_state,
      output main_state, counter, flick_sync, kickback_match
   );
endinterface

// File: rtl/flasher_state_datapath.sv
// Register-and-datapath stage of the bound flasher.
// Holds the main state and 5-bit LED counter, synchronises the raw flick
// input, raises kickback_match at the bound points and drives the LED bar.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   flick       : asynchronous user input
//   bus         : generator bus (slave side)
//   led         : 16-bit thermometer decode of counter (0 in illegal state 7)
//   cycle_done  : one-cycle pulse after the OFF5_0 -> INIT transition
module flasher_state_datapath #(
   parameter int SYNC_STAGES = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      flick,
   flasher_state_datapath_if.slave   bus,
   output logic [15:0]               led,
   output logic                      cycle_done
);

   typedef enum logic [1:0] {
      CNT_HOLD  = 2'd0,
      CNT_UP    = 2'd1,
      CNT_DOWN  = 2'd2,
      CNT_HOLD3 = 2'd3
   } count_e;

   localparam logic [2:0] ST_INIT    = 3'd0;
   localparam logic [2:0] ST_OFF15_5 = 3'd2;
   localparam logic [2:0] ST_OFF10_0 = 3'd4;
   localparam logic [2:0] ST_OFF5_0  = 3'd6;
   localparam logic [2:0] ST_ILLEGAL = 3'd7;

   logic [2:0]             main_state_q;
   logic [4:0]             counter_q;
   logic [4:0]             counter_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   cycle_done_q;
   count_e                 cnt_op;

   assign cnt_op = count_e'(bus.count_state);

   // Load beats counting; count saturates at both ends.
   always_comb begin
      counter_d = counter_q;
      if (bus.counter_load_en) begin
         counter_d = bus.counter_load;
      end else begin
         case (cnt_op)
            CNT_UP:   if (counter_q != 5'd31) counter_d = counter_q + 5'd1;
            CNT_DOWN: if (counter_q != 5'd0)  counter_d = counter_q - 5'd1;
            default:  counter_d = counter_q;
         endcase
      end
   end

   generate
      if (SYNC_STAGES > 1) begin : g_sync_chain
         always_ff @(posedge clk) begin
            if (!rst_n) sync_q <= '0;
            else        sync_q <= {sync_q[SYNC_STAGES-2:0], flick};
         end
      end else begin : g_sync_single
         always_ff @(posedge clk) begin
            if (!rst_n) sync_q <= '0;
            else        sync_q <= flick;
         end
      end
   endgenerate

   // State is taken unfiltered; the generator is responsible for recovering
   // from code 7.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         main_state_q <= ST_INIT;
         counter_q    <= '0;
         cycle_done_q <= 1'b0;
      end else begin
         main_state_q <= bus.main_state_n;
         counter_q    <= counter_d;
         cycle_done_q <= (main_state_q == ST_OFF5_0) && (bus.main_state_n == ST_INIT);
      end
   end

   assign bus.main_state = main_state_q;
   assign bus.counter    = counter_q;
   assign bus.flick_sync = sync_q[SYNC_STAGES-1];
   assign cycle_done     = cycle_done_q;

   // Registered values only: no combinational path back to the generator.
   assign bus.kickback_match = sync_q[SYNC_STAGES-1] &&
      (((main_state_q == ST_OFF15_5) && (counter_q == 5'd5)) ||
       ((main_state_q == ST_OFF10_0) && (counter_q == 5'd0)));

   // Counts >= 16 naturally light every bit.
   generate
      for (genvar i = 0; i < 16; i++) begin : g_led
         assign led[i] = (main_state_q != ST_ILLEGAL) && (counter_q > 5'(i));
      end
   endgenerate

endmodule

// File: tb/tb_flasher_state_datapath.sv
module tb_flasher_state_datapath;

   logic        clk;
   logic        rst_n;
   logic        flick;
   logic [15:0] led, led3, led4;
   logic        cycle_done, cd3, cd4;
   int          checks;
   int          failures;

   flasher_state_datapath_if bus ();
   flasher_state_datapath_if bus3 ();
   flasher_state_datapath_if bus4 ();

   flasher_state_datapath #(.SYNC_STAGES(2)) dut (
      .clk(clk), .rst_n(rst_n), .flick(flick), .bus(bus),
      .led(led), .cycle_done(cycle_done)
   );
   flasher_state_datapath #(.SYNC_STAGES(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .flick(flick), .bus(bus3),
      .led(led3), .cycle_done(cd3)
   );
   flasher_state_datapath #(.SYNC_STAGES(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .flick(flick), .bus(bus4),
      .led(led4), .cycle_done(cd4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] ms_n, input logic ld_en,
                        input logic [4:0] ld, input logic [1:0] cs);
      bus.main_state_n    = ms_n;
      bus.counter_load_en = ld_en;
      bus.counter_load    = ld;
      bus.count_state     = cs;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      flick = 1'b0;
      drive(3'd1, 1'b1, 5'd9, 2'd1);
      tick();
      checks++;
      if (bus.main_state !== 3'd0) begin
         failures++; $display("FAIL reset_state got=%0d exp=0", bus.main_state);
      end
      checks++;
      if (bus.counter !== 5'd0) begin
         failures++; $display("FAIL reset_counter got=%0d exp=0", bus.counter);
      end
      checks++;
      if ({bus.flick_sync, bus.kickback_match, cycle_done, led} !== 19'd0) begin
         failures++; $display("FAIL reset_outputs got=%0h exp=0",
                              {bus.flick_sync, bus.kickback_match, cycle_done, led});
      end
      rst_n = 1'b1;
      drive(3'd0, 1'b0, 5'd0, 2'd0);
      tick();
   endtask

   task automatic test_reset_mid_count();
      drive(3'd1, 1'b0, 5'd0, 2'd1);
      for (int i = 0; i < 7; i++) tick();
      checks++;
      if (bus.counter !== 5'd7 || bus.main_state !== 3'd1) begin
         failures++; $display("FAIL midcount_pre got=%0d/%0d exp=7/1", bus.counter, bus.main_state);
      end
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      drive(3'd0, 1'b0, 5'd0, 2'd0);
      checks++;
      if (bus.counter !== 5'd0 || bus.main_state !== 3'd0 || led !== 16'd0 || cycle_done !== 1'b0) begin
         failures++; $display("FAIL midcount_reset got=cnt%0d st%0d led%0h cd%0b exp=0",
                              bus.counter, bus.main_state, led, cycle_done);
      end
   endtask

   task automatic test_sync_latency();
      flick = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      flick = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         tick();
         checks++;
         if (bus.flick_sync !== (k >= 2)) begin
            failures++; $display("FAIL sync2_k%0d got=%0b exp=%0b", k, bus.flick_sync, k >= 2);
         end
         checks++;
         if (bus3.flick_sync !== (k >= 3)) begin
            failures++; $display("FAIL sync3_k%0d got=%0b exp=%0b", k, bus3.flick_sync, k >= 3);
         end
         checks++;
         if (bus4.flick_sync !== (k >= 4)) begin
            failures++; $display("FAIL sync4_k%0d got=%0b exp=%0b", k, bus4.flick_sync, k >= 4);
         end
      end
   endtask

   task automatic test_up_saturation();
      drive(3'd1, 1'b1, 5'd0, 2'd0);
      tick();
      drive(3'd1, 1'b0, 5'd0, 2'd1);
      for (int i = 0; i < 5; i++) tick();
      checks++;
      if (led !== 16'h001F) begin
         failures++; $display("FAIL led_at5 got=%0h exp=001f", led);
      end
      for (int i = 0; i < 11; i++) tick();
      checks++;
      if (bus.counter !== 5'd16 || led !== 16'hFFFF) begin
         failures++; $display("FAIL up16 got=%0d/%0h exp=16/ffff", bus.counter, led);
      end
      for (int i = 0; i < 15; i++) tick();
      checks++;
      if (bus.counter !== 5'd31) begin
         failures++; $display("FAIL up31 got=%0d exp=31", bus.counter);
      end
      tick();
      checks++;
      if (bus.counter !== 5'd31 || led !== 16'hFFFF) begin
         failures++; $display("FAIL sat31 got=%0d/%0h exp=31/ffff", bus.counter, led);
      end
      // generator's 1 -> 2 transition: counter 16 -> 15 on the same edge
      drive(3'd1, 1'b1, 5'd16, 2'd0);
      tick();
      drive(3'd2, 1'b0, 5'd0, 2'd2);
      tick();
      checks++;
      if (bus.counter !== 5'd15 || bus.main_state !== 3'd2 || led !== 16'h7FFF) begin
         failures++; $display("FAIL trans1_2 got=cnt%0d st%0d led%0h exp=15/2/7fff",
                              bus.counter, bus.main_state, led);
      end
      drive(3'd5, 1'b1, 5'd0, 2'd0);
      tick();
      drive(3'd5, 1'b0, 5'd0, 2'd2);
      tick();
      checks++;
      if (bus.counter !== 5'd0 || led !== 16'd0) begin
         failures++; $display("FAIL sat0 got=%0d/%0h exp=0/0", bus.counter, led);
      end
   endtask

   task automatic test_kickback();
      // flick has been high since the sync test
      drive(3'd2, 1'b1, 5'd5, 2'd0);
      tick();
      checks++;
      if (bus.kickback_match !== 1'b1) begin
         failures++; $display("FAIL kick_s2_c5 got=%0b exp=1", bus.kickback_match);
      end
      drive(3'd2, 1'b1, 5'd6, 2'd0);
      tick();
      checks++;
      if (bus.kickback_match !== 1'b0) begin
         failures++; $display("FAIL kick_s2_c6 got=%0b exp=0", bus.kickback_match);
      end
      drive(3'd1, 1'b1, 5'd5, 2'd0);
      tick();
      checks++;
      if (bus.kickback_match !== 1'b0) begin
         failures++; $display("FAIL kick_s1_c5 got=%0b exp=0", bus.kickback_match);
      end
      drive(3'd4, 1'b1, 5'd0, 2'd0);
      tick();
      checks++;
      if (bus.kickback_match !== 1'b1) begin
         failures++; $display("FAIL kick_s4_c0 got=%0b exp=1", bus.kickback_match);
      end
      drive(3'd4, 1'b0, 5'd0, 2'd0);
      flick = 1'b0;
      tick();
      checks++;
      if (bus.kickback_match !== 1'b1) begin
         failures++; $display("FAIL kick_s4_lat1 got=%0b exp=1", bus.kickback_match);
      end
      tick();
      checks++;
      if (bus.kickback_match !== 1'b0) begin
         failures++; $display("FAIL kick_s4_nf got=%0b exp=0", bus.kickback_match);
      end
      flick = 1'b1;
      tick();
      tick();
   endtask

   task automatic test_load_priority();
      drive(3'd3, 1'b1, 5'd4, 2'd0);
      tick();
      drive(3'd3, 1'b1, 5'd16, 2'd2);
      tick();
      checks++;
      if (bus.counter !== 5'd16 || led !== 16'hFFFF) begin
         failures++; $display("FAIL load_prio got=%0d/%0h exp=16/ffff", bus.counter, led);
      end
      drive(3'd3, 1'b1, 5'd9, 2'd1);
      tick();
      checks++;
      if (bus.counter !== 5'd9 || led !== 16'h01FF) begin
         failures++; $display("FAIL load_prio_up got=%0d/%0h exp=9/01ff", bus.counter, led);
      end
   endtask

   task automatic test_back_to_back();
      drive(3'd6, 1'b1, 5'd5, 2'd0);
      tick();
      checks++;
      if (cycle_done !== 1'b0 || bus.kickback_match !== 1'b0) begin
         failures++; $display("FAIL s6_entry got=cd%0b kb%0b exp=0/0", cycle_done, bus.kickback_match);
      end
      drive(3'd6, 1'b0, 5'd0, 2'd0);
      tick();
      checks++;
      if (cycle_done !== 1'b0) begin
         failures++; $display("FAIL s6_hold got=%0b exp=0", cycle_done);
      end
      drive(3'd0, 1'b0, 5'd0, 2'd0);
      tick();
      checks++;
      if (cycle_done !== 1'b1 || bus.main_state !== 3'd0) begin
         failures++; $display("FAIL cycle_done got=%0b st%0d exp=1/0", cycle_done, bus.main_state);
      end
      tick();
      checks++;
      if (cycle_done !== 1'b0) begin
         failures++; $display("FAIL cycle_done_pulse got=%0b exp=0", cycle_done);
      end
      drive(3'd7, 1'b1, 5'd5, 2'd0);
      tick();
      checks++;
      if (bus.main_state !== 3'd7 || led !== 16'd0 || bus.kickback_match !== 1'b0) begin
         failures++; $display("FAIL illegal7 got=st%0d led%0h kb%0b exp=7/0/0",
                              bus.main_state, led, bus.kickback_match);
      end
      drive(3'd7, 1'b1, 5'd0, 2'd0);
      tick();
      checks++;
      if (led !== 16'd0 || bus.kickback_match !== 1'b0 || bus.counter !== 5'd0) begin
         failures++; $display("FAIL illegal7_c0 got=led%0h kb%0b cnt%0d exp=0/0/0",
                              led, bus.kickback_match, bus.counter);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      flick    = 1'b0;
      drive(3'd0, 1'b0, 5'd0, 2'd0);
      bus3.main_state_n = 3'd0; bus3.counter_load = 5'd0;
      bus3.counter_load_en = 1'b0; bus3.count_state = 2'd0;
      bus4.main_state_n = 3'd0; bus4.counter_load = 5'd0;
      bus4.counter_load_en = 1'b0; bus4.count_state = 2'd0;
      tick();
      test_reset();
      test_reset_mid_count();
      test_sync_latency();
      test_up_saturation();
      test_kickback();
      test_load_priority();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
